traffic_phase_sequencer: RTL

- Timed controller for a two-road intersection.
- Drives the 2-bit NS (main road) and EW (side road) light codes from a single phase FSM plus one duration counter.
- The side-road car sensor x requests EW service. Minimum-green, yellow, all-red clearance and maximum side-green times are enforced in clk cycles.
- Top-level instance of the traffic-light subsystem.

---
 rtl/traffic_phase_sequencer_pkg.sv | 41 ++++
 rtl/traffic_phase_sequencer_phase_timer.sv | 29 ++
 rtl/traffic_phase_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/traffic_phase_sequencer_pkg.sv
// Shared types and light decoding for the traffic-light subsystem.
// Imported by traffic_phase_sequencer and phase_timer.
package traffic_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2
  } light_t;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5
  } phase_t;

  // Main-road light for a given phase; anything outside the NS phases is red.
  function automatic light_t ns_light(input phase_t p);
    case (p)
      NS_GREEN:  return GREEN;
      NS_YELLOW: return YELLOW;
      default:   return RED;
    endcase
  endfunction

  // Side-road light for a given phase; anything outside the EW phases is red.
  function automatic light_t ew_light(input phase_t p);
    case (p)
      EW_GREEN:  return GREEN;
      EW_YELLOW: return YELLOW;
      default:   return RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_phase_sequencer_phase_timer.sv
// Saturating phase duration counter: synchronous clr restarts it, clear=0 resets it.
module phase_timer
  import traffic_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          clr,
  output logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  // Count cycles spent in the current phase, holding at the top value.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      cnt <= {CW{1'b0}};
    end else if (clr == TRUE) begin
      cnt <= {CW{1'b0}};
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_ONE;
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Two-road intersection phase sequencer with registered light outputs.
// Optional pedestrian service is enabled with the PED_REQ_EN macro.
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int CW           = 8,
  parameter int MIN_GREEN    = 8,
  parameter int MAX_EW_GREEN = 16,
  parameter int YELLOW_TIME  = 3,
  parameter int ALLRED_TIME  = 2
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       x,
`ifdef PED_REQ_EN
  input  logic       ped_req,
  output logic       ped_walk,
`endif
  output logic [1:0] NS,
  output logic [1:0] EW,
  output logic [2:0] phase
);

  // Counter values at which each timed phase has run its full length.
  localparam logic [CW-1:0] MIN_LAST    = CW'(MIN_GREEN - 1);
  localparam logic [CW-1:0] MAX_EW_LAST = CW'(MAX_EW_GREEN - 1);
  localparam logic [CW-1:0] YELLOW_LAST = CW'(YELLOW_TIME - 1);
  localparam logic [CW-1:0] ALLRED_LAST = CW'(ALLRED_TIME - 1);

  phase_t        state_r;
  phase_t        state_nxt_s;
  logic [CW-1:0] cnt_s;
  logic          clr_s;
  logic          ns_req_s;
  logic          ew_hold_s;

  phase_timer #(
    .CW(CW)
  ) u_timer (
    .clk  (clk),
    .clear(clear),
    .clr  (clr_s),
    .cnt  (cnt_s)
  );

`ifdef PED_REQ_EN
  logic ped_pend_r;
  logic serve_s;

  // Decide whether this EW green entry serves a pending pedestrian and how requests combine.
  always_comb begin
    serve_s = FALSE;
    if ((state_r == ALLRED_A) && (state_nxt_s == EW_GREEN) && (ped_pend_r == TRUE)) begin
      serve_s = TRUE;
    end else begin
      serve_s = FALSE;
    end
    ns_req_s  = x | ped_pend_r;
    ew_hold_s = ped_walk & ((cnt_s < MIN_LAST) ? TRUE : FALSE);
  end

  // Sticky pedestrian request and walk indication for the served EW green phase.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      ped_pend_r <= FALSE;
      ped_walk   <= FALSE;
    end else begin
      // A request arriving on the serving edge itself waits for the next round.
      ped_pend_r <= ped_req | (ped_pend_r & ~serve_s);
      if (state_nxt_s != EW_GREEN) begin
        ped_walk <= FALSE;
      end else if (serve_s == TRUE) begin
        ped_walk <= TRUE;
      end else begin
        ped_walk <= ped_walk;
      end
    end
  end
`else
  // Without pedestrian service only the car sensor requests EW, and EW green has no minimum.
  always_comb begin
    ns_req_s  = x;
    ew_hold_s = FALSE;
  end
`endif

  // Next-phase selection from the current phase, elapsed count and requests.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      NS_GREEN: begin
        if ((cnt_s >= MIN_LAST) && (ns_req_s == TRUE)) begin
          state_nxt_s = NS_YELLOW;
        end else begin
          state_nxt_s = NS_GREEN;
        end
      end
      NS_YELLOW: begin
        if (cnt_s == YELLOW_LAST) begin
          state_nxt_s = ALLRED_A;
        end else begin
          state_nxt_s = NS_YELLOW;
        end
      end
      ALLRED_A: begin
        if (cnt_s == ALLRED_LAST) begin
          state_nxt_s = EW_GREEN;
        end else begin
          state_nxt_s = ALLRED_A;
        end
      end
      EW_GREEN: begin
        if ((cnt_s == MAX_EW_LAST) || ((x == FALSE) && (ew_hold_s == FALSE))) begin
          state_nxt_s = EW_YELLOW;
        end else begin
          state_nxt_s = EW_GREEN;
        end
      end
      EW_YELLOW: begin
        if (cnt_s == YELLOW_LAST) begin
          state_nxt_s = ALLRED_B;
        end else begin
          state_nxt_s = EW_YELLOW;
        end
      end
      ALLRED_B: begin
        if (cnt_s == ALLRED_LAST) begin
          state_nxt_s = NS_GREEN;
        end else begin
          state_nxt_s = ALLRED_B;
        end
      end
      default: begin
        state_nxt_s = NS_GREEN;
      end
    endcase
  end

  // Any phase change, including recovery from an illegal encoding, restarts the timer.
  always_comb begin
    if (state_nxt_s != state_r) begin
      clr_s = TRUE;
    end else begin
      clr_s = FALSE;
    end
  end

  // Phase register with lights decoded from the next phase so they change on the same edge.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_r <= NS_GREEN;
      NS      <= GREEN;
      EW      <= RED;
      phase   <= 3'd0;
    end else begin
      state_r <= state_nxt_s;
      NS      <= ns_light(state_nxt_s);
      EW      <= ew_light(state_nxt_s);
      phase   <= state_nxt_s;
    end
  end

endmodule
